amult_arbiter: RTL and testbench

Shares one approximate shift-add multiplier among NUM_REQ softmax lanes in the multiple-input handling path. Each lane presents an operand and a shift mask with a valid/ready handshake. The block arbitrates between lanes, registers the winning operands, computes the approximate product, and returns it through a single tagged, back-pressurable response port. Throughput is one product per cycle; latency is fixed at 2 cycles.

---
 rtl/amult_pkg.sv | 30 +++
 rtl/amult_rr_grant.sv | 41 ++++
 rtl/amult_arbiter.sv | 124 ++++++++++++
 tb/tb_amult_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amult_pkg.sv
// amult_pkg: shared constants and helpers for the shared approximate
// shift-add multiplier arbiter.
//   clog2_min1(n)     : index width for n lanes, never less than 1
//   amult_f(d, m, sw) : approximate product; mask bit sw-1 weights 2^-1,
//                       bit 0 weights 2^-sw; arithmetic shifts, sum wraps
//                       at the operand width (caller truncates).
package amult_pkg;

  localparam int unsigned AMULT_DEF_WIDTH = 32;
  localparam int unsigned AMULT_DEF_SHIFT = 16;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Operates on a 64-bit sign-extended operand so one function serves any
  // WIDTH/SHIFT up to 64; truncating the 64-bit sum to WIDTH bits gives the
  // same modulo-2^WIDTH result as summing the narrow shifted terms.
  function automatic logic [63:0] amult_f(input logic signed [63:0] dat,
                                          input logic [63:0]        shift,
                                          input int unsigned        shift_w);
    logic [63:0] acc;
    acc = '0;
    for (int unsigned k = 1; k <= shift_w; k++) begin
      if (shift[6'(shift_w - k)]) acc = acc + 64'(dat >>> k);
    end
    return acc;
  endfunction

endpackage

// File: rtl/amult_rr_grant.sv
// amult_rr_grant: round-robin grant for the multiplier arbiter. Only built
// when AMULT_ARB_RR_EN is defined.
//   i_req : request vector
//   i_ptr : lane where the search starts (wraps modulo NUM_REQ)
//   i_en  : grant enable; when low no grant is issued
//   o_gnt : one-hot grant (zero when nothing requested or disabled)
//   o_idx : encoded index of the granted lane
`ifdef AMULT_ARB_RR_EN
module amult_rr_grant import amult_pkg::*; #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);

  int unsigned w_lane;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_lane  = 0;
    w_found = 1'b0;
    if (i_en) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        w_lane = (32'(i_ptr) + i) % NUM_REQ;
        if (!w_found && i_req[ID_W'(w_lane)]) begin
          w_found               = 1'b1;
          o_gnt[ID_W'(w_lane)]  = 1'b1;
          o_idx                 = ID_W'(w_lane);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/amult_arbiter.sv
// amult_arbiter: shares one approximate shift-add multiplier among NUM_REQ
// lanes. Two-stage pipeline (S1 operand register, S2 result register),
// fixed 2-cycle latency, one product per cycle, back-pressurable response.
// Arbitration: round-robin when AMULT_ARB_RR_EN is defined, otherwise fixed
// priority (lowest index wins).
//   CLK, RST   : clock, synchronous active-high reset
//   REQ_VALID  : per-lane request valid
//   REQ_READY  : per-lane accept, one-hot or zero
//   REQ_DAT    : lane i signed operand at [i*WIDTH +: WIDTH]
//   REQ_SHIFT  : lane i mask at [i*SHIFT +: SHIFT]
//   RSP_VALID / RSP_READY / RSP_DAT / RSP_ID : tagged response port
//   BUSY       : either pipeline stage holds data
module amult_arbiter import amult_pkg::*; #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = AMULT_DEF_WIDTH,
  parameter  int unsigned SHIFT   = AMULT_DEF_SHIFT,
  localparam int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  output logic [NUM_REQ-1:0]         REQ_READY,
  input  logic [NUM_REQ*WIDTH-1:0]   REQ_DAT,
  input  logic [NUM_REQ*SHIFT-1:0]   REQ_SHIFT,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic [WIDTH-1:0]           RSP_DAT,
  output logic [ID_W-1:0]            RSP_ID,
  output logic                       BUSY
);

  logic                     r_v1;
  logic signed [WIDTH-1:0]  r_dat;
  logic [SHIFT-1:0]         r_shift;
  logic [ID_W-1:0]          r_id;
  logic                     r_rsp_valid;
  logic [WIDTH-1:0]         r_rsp_dat;
  logic [ID_W-1:0]          r_rsp_id;

  logic                     w_adv2;
  logic                     w_adv1;
  logic                     w_en;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [ID_W-1:0]          w_idx;
  logic                     w_fire;
  logic [WIDTH-1:0]         w_prod;

  assign w_adv2 = !r_rsp_valid || RSP_READY;
  assign w_adv1 = !r_v1 || w_adv2;
  assign w_en   = w_adv1 && !RST;

`ifdef AMULT_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;

  amult_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .i_req (REQ_VALID),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST)         r_ptr <= '0;
    else if (w_fire) r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  end
`else
  logic w_found;

  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (w_en) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && REQ_VALID[ID_W'(i)]) begin
          w_found           = 1'b1;
          w_gnt[ID_W'(i)]   = 1'b1;
          w_idx             = ID_W'(i);
        end
      end
    end
  end
`endif

  assign w_fire    = |w_gnt;
  assign REQ_READY = w_gnt;
  assign w_prod    = WIDTH'(amult_f(64'(r_dat), 64'(r_shift), SHIFT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1        <= 1'b0;
      r_dat       <= '0;
      r_shift     <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_id    <= '0;
    end else begin
      // S2 drain, S1->S2 move and a new S1 accept can all happen on one edge.
      if (w_adv2) begin
        r_rsp_valid <= r_v1;
        if (r_v1) begin
          r_rsp_dat <= w_prod;
          r_rsp_id  <= r_id;
        end
      end
      if (w_adv1) begin
        r_v1 <= w_fire;
        if (w_fire) begin
          r_dat   <= REQ_DAT[32'(w_idx)*WIDTH +: WIDTH];
          r_shift <= REQ_SHIFT[32'(w_idx)*SHIFT +: SHIFT];
          r_id    <= w_idx;
        end
      end
    end
  end

  assign RSP_VALID = r_rsp_valid;
  assign RSP_DAT   = r_rsp_dat;
  assign RSP_ID    = r_rsp_id;
  assign BUSY      = r_v1 || r_rsp_valid;

endmodule

// File: tb/tb_amult_arbiter.sv
// tb_amult_arbiter: directed checks of amult_arbiter (reset, single lane,
// sign/sum, backpressure, mid-operation reset, contention) followed by a
// random-valid scoreboard run. Expected ID orders follow AMULT_ARB_RR_EN.
module tb_amult_arbiter;

  logic          CLK = 1'b0;
  logic          RST;
  logic [3:0]    REQ_VALID;
  logic [3:0]    REQ_READY;
  logic [127:0]  REQ_DAT;
  logic [63:0]   REQ_SHIFT;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [31:0]   RSP_DAT;
  logic [1:0]    RSP_ID;
  logic          BUSY;

  logic [31:0]   t_dat [4];
  logic [15:0]   t_sh  [4];

  assign REQ_DAT   = {t_dat[3], t_dat[2], t_dat[1], t_dat[0]};
  assign REQ_SHIFT = {t_sh[3], t_sh[2], t_sh[1], t_sh[0]};

  amult_arbiter #(.NUM_REQ(4), .WIDTH(32), .SHIFT(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_DAT   (REQ_DAT),
    .REQ_SHIFT (REQ_SHIFT),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DAT   (RSP_DAT),
    .RSP_ID    (RSP_ID),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: each set mask bit b adds the operand halved (16-b) times.
  function automatic logic [31:0] ref_amult(input logic [31:0] d, input logic [15:0] m);
    logic signed [31:0] acc;
    logic signed [31:0] v;
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (m[b]) begin
        v = d;
        for (int k = 0; k < 16 - b; k++) v = v >>> 1;
        acc = acc + v;
      end
    end
    return acc;
  endfunction

  logic [1:0]  exp_bp   [2];
  logic [31:0] exp_bpd  [2];
  logic [1:0]  exp_cont [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n_acc;
    int          n_xfer;
    int          cycles;
    logic [3:0]  acc_last;
    logic [1:0]  g;
    logic [1:0]  q_id  [$];
    logic [31:0] q_dat [$];
    logic [1:0]  e_id;
    logic [31:0] e_dat;

`ifdef AMULT_ARB_RR_EN
    exp_bp   = '{2'd2, 2'd3};
    exp_bpd  = '{32'h0001_8000, 32'h0002_0000};
    exp_cont = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
    exp_bp   = '{2'd0, 2'd0};
    exp_bpd  = '{32'h0000_8000, 32'h0000_8000};
    exp_cont = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset
    RST = 1'b1; REQ_VALID = '0; RSP_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin t_dat[i] = '0; t_sh[i] = '0; end
    step(); step();
    REQ_VALID = 4'b0001; t_dat[0] = 32'h0001_0000; t_sh[0] = 16'h8000;
    #1;
    chk("reset_ready", REQ_READY, 4'b0000);
    chk("reset_valid", RSP_VALID, 1'b0);
    chk("reset_busy",  BUSY,      1'b0);
    chk("reset_dat",   RSP_DAT,   32'h0);
    RST = 1'b0;
    #1;
    chk("single_grant", REQ_READY, 4'b0001);

    // Single lane 0, 2-cycle latency
    step();
    REQ_VALID = '0;
    #1;
    chk("single_lat1", RSP_VALID, 1'b0);
    chk("single_busy", BUSY,      1'b1);
    step();
    chk("single_valid", RSP_VALID, 1'b1);
    chk("single_dat",   RSP_DAT,   32'h0000_8000);
    chk("single_id",    RSP_ID,    2'd0);
    step();
    chk("single_drain", RSP_VALID, 1'b0);
    chk("single_idle",  BUSY,      1'b0);

    // Sign-preserving sum, then an all-zero mask back to back
    t_dat[2] = 32'hFFFF_0000; t_sh[2] = 16'hC000; REQ_VALID = 4'b0100;
    #1;
    chk("sign_grant", REQ_READY, 4'b0100);
    step();
    t_dat[1] = 32'h1234_5678; t_sh[1] = 16'h0000; REQ_VALID = 4'b0010;
    #1;
    chk("zero_grant", REQ_READY, 4'b0010);
    step();
    REQ_VALID = '0;
    #1;
    chk("sign_valid", RSP_VALID, 1'b1);
    chk("sign_dat",   RSP_DAT,   32'hFFFF_4000);
    chk("sign_id",    RSP_ID,    2'd2);
    step();
    chk("zero_dat", RSP_DAT, 32'h0);
    chk("zero_id",  RSP_ID,  2'd1);
    step();
    chk("sign_idle", BUSY, 1'b0);

    // Backpressure: 5 cycles of RSP_READY low with all lanes valid
    for (int i = 0; i < 4; i++) begin
      t_dat[i] = 32'(i + 1) << 16;
      t_sh[i]  = 16'h8000;
    end
    RSP_READY = 1'b0; REQ_VALID = 4'b1111;
    #1;
    n_acc = 0;
    for (int c = 0; c < 5; c++) begin
      if (|REQ_READY) n_acc++;
      step();
      if (c >= 1) begin
        chk("bp_valid", RSP_VALID, 1'b1);
        chk("bp_dat",   RSP_DAT,   exp_bpd[0]);
        chk("bp_id",    RSP_ID,    exp_bp[0]);
      end
    end
    chk("bp_accepts",    n_acc,     2);
    chk("bp_ready_zero", REQ_READY, 4'b0000);
    RSP_READY = 1'b1;
    #1;
    chk("bp_release_grant", REQ_READY, 4'b0001);
    step();
    chk("bp_second_valid", RSP_VALID, 1'b1);
    chk("bp_second_dat",   RSP_DAT,   exp_bpd[1]);
    chk("bp_second_id",    RSP_ID,    exp_bp[1]);
    chk("bp_full_busy",    BUSY,      1'b1);

    // Reset with both stages full
    RST = 1'b1;
    #1;
    chk("rst_ready", REQ_READY, 4'b0000);
    step();
    RST = 1'b0;
    #1;
    chk("rst_valid", RSP_VALID, 1'b0);
    chk("rst_busy",  BUSY,      1'b0);
    chk("rst_dat",   RSP_DAT,   32'h0);
    chk("rst_id",    RSP_ID,    2'd0);
    chk("rst_grant", REQ_READY, 4'b0001);

    // Contention: all lanes valid, consumer always ready
    for (int c = 0; c < 7; c++) begin
      step();
      if (c >= 1) begin
        chk("cont_valid", RSP_VALID, 1'b1);
        chk("cont_id",    RSP_ID,    exp_cont[c-1]);
        chk("cont_dat",   RSP_DAT,   32'(exp_cont[c-1] + 1) << 15);
      end
    end
    REQ_VALID = '0;
    step(); step(); step();
    chk("cont_idle", BUSY, 1'b0);

    // Random scoreboard
    n_xfer   = 0;
    cycles   = 0;
    acc_last = '0;
    while (n_xfer < 2000 && cycles < 20000) begin
      for (int i = 0; i < 4; i++) begin
        if (!REQ_VALID[i] || acc_last[i]) begin
          REQ_VALID[i] = 1'($urandom_range(0, 1));
          t_dat[i]     = $urandom;
          t_sh[i]      = 16'($urandom);
        end
      end
      RSP_READY = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_onehot", {$onehot0(REQ_READY), (REQ_READY & ~REQ_VALID)}, {1'b1, 4'b0000});
      chk("rnd_ready_any", |REQ_READY,
          (|REQ_VALID) && !(q_id.size() == 2 && !RSP_READY));
      if (RSP_VALID && RSP_READY) begin
        if (q_id.size() == 0) begin
          chk("rnd_spurious", q_id.size(), 1);
        end else begin
          e_id  = q_id.pop_front();
          e_dat = q_dat.pop_front();
          chk("rnd_resp", {RSP_ID, RSP_DAT}, {e_id, e_dat});
          n_xfer++;
        end
      end
      acc_last = REQ_READY;
      if (|REQ_READY) begin
        g = '0;
        for (int i = 0; i < 4; i++) if (REQ_READY[i]) g = 2'(i);
        q_id.push_back(g);
        q_dat.push_back(ref_amult(t_dat[g], t_sh[g]));
      end
      step();
      cycles++;
    end
    chk("rnd_count", n_xfer, 2000);

    REQ_VALID = '0; RSP_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (RSP_VALID) begin
        if (q_id.size() == 0) begin
          chk("rnd_drain_spurious", q_id.size(), 1);
        end else begin
          e_id  = q_id.pop_front();
          e_dat = q_dat.pop_front();
          chk("rnd_drain_resp", {RSP_ID, RSP_DAT}, {e_id, e_dat});
        end
      end
      step();
    end
    chk("rnd_leftover", q_id.size(), 0);
    chk("rnd_idle",     BUSY,        1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
